// File: rtl/path_replayer.sv
// path_replayer: drains the solver's location stack and streams one move per location step;
// best case one move per 3 cycles, pops stall while a move waits on move_ready. Adjacency check/ERR under `PATH_REPLAYER_CHECK_EN.
module path_replayer #(
  parameter int COORD_W = 4,
  parameter int LEN_W   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 emp_stck,
  input  logic [2*COORD_W-1:0] loc_in,
  output logic                 pop,
  output logic                 move_valid,
  input  logic                 move_ready,
  output logic [1:0]           move_dir,
  output logic [2*COORD_W-1:0] move_loc,
  output logic [LEN_W-1:0]     path_len,
  output logic                 busy,
  output logic                 finished,
  output logic                 err
);

  localparam logic [1:0] X_INC = 2'b00;
  localparam logic [1:0] X_DEC = 2'b01;
  localparam logic [1:0] Y_INC = 2'b10;
  localparam logic [1:0] Y_DEC = 2'b11;

`ifdef PATH_REPLAYER_CHECK_EN
  typedef enum logic [2:0] {IDLE, POP, WAIT, EMIT, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, POP, WAIT, EMIT, DONE} state_t;
`endif

  state_t state, nextState;

  logic [2*COORD_W-1:0] prevLoc;
  logic                 first;
  logic                 startRun, takeOrigin, loadMove, accept;
  logic [1:0]           stepDir;

  // Unsigned coordinates widened by one bit so a 15->0 step reads as -15, never as +1.
  logic signed [COORD_W:0] dx, dy;
  assign dx = $signed({1'b0, loc_in[2*COORD_W-1:COORD_W]}) - $signed({1'b0, prevLoc[2*COORD_W-1:COORD_W]});
  assign dy = $signed({1'b0, loc_in[COORD_W-1:0]}) - $signed({1'b0, prevLoc[COORD_W-1:0]});

`ifdef PATH_REPLAYER_CHECK_EN
  localparam logic signed [COORD_W:0] PLUS1  = (COORD_W+1)'(1);
  localparam logic signed [COORD_W:0] MINUS1 = '1;
  localparam logic signed [COORD_W:0] ZERO   = '0;
  logic stepOk;

  always_comb begin
    stepDir = Y_INC;
    stepOk  = 1'b1;
    if (dx == PLUS1 && dy == ZERO)       stepDir = X_INC;
    else if (dx == MINUS1 && dy == ZERO) stepDir = X_DEC;
    else if (dx == ZERO && dy == PLUS1)  stepDir = Y_INC;
    else if (dx == ZERO && dy == MINUS1) stepDir = Y_DEC;
    else                                 stepOk  = 1'b0;
  end
`else
  always_comb begin
    stepDir = Y_INC;
    if (dx != '0)               stepDir = dx[COORD_W] ? X_DEC : X_INC;
    else if (dy[COORD_W])       stepDir = Y_DEC;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState  = state;
    startRun   = 1'b0;
    takeOrigin = 1'b0;
    loadMove   = 1'b0;
    accept     = 1'b0;
    case (state)
`ifdef PATH_REPLAYER_CHECK_EN
      IDLE, DONE, ERR: begin
`else
      IDLE, DONE: begin
`endif
        if (start) begin
          startRun  = 1'b1;
          nextState = emp_stck ? DONE : POP;
        end
      end
      POP: nextState = WAIT;
      WAIT: begin
        if (first) begin
          // The origin only seeds prevLoc; it is never emitted as a move.
          takeOrigin = 1'b1;
          nextState  = emp_stck ? DONE : POP;
        end else begin
`ifdef PATH_REPLAYER_CHECK_EN
          if (stepOk) begin
            loadMove  = 1'b1;
            nextState = EMIT;
          end else begin
            nextState = ERR;
          end
`else
          loadMove  = 1'b1;
          nextState = EMIT;
`endif
        end
      end
      EMIT: begin
        if (move_ready) begin
          accept    = 1'b1;
          nextState = emp_stck ? DONE : POP;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prevLoc  <= '0;
      first    <= 1'b1;
      move_dir <= '0;
      move_loc <= '0;
      path_len <= '0;
    end else begin
      if (startRun) begin
        path_len <= '0;
        first    <= 1'b1;
      end
      if (takeOrigin) begin
        prevLoc <= loc_in;
        first   <= 1'b0;
      end
      if (loadMove) begin
        move_dir <= stepDir;
        move_loc <= loc_in;
      end
      if (accept) begin
        prevLoc <= move_loc;
        if (path_len != '1) path_len <= path_len + 1'b1;
      end
    end
  end

  assign pop        = (state == POP);
  assign move_valid = (state == EMIT);
  assign busy       = (state == POP) || (state == WAIT) || (state == EMIT);
  assign finished   = (state == DONE);
`ifdef PATH_REPLAYER_CHECK_EN
  assign err        = (state == ERR);
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_path_replayer.sv
// Bench for path_replayer: behavioural stack model feeds locations, scoreboard checks every accepted move.
module tb_path_replayer;
  localparam logic [1:0] X_INC = 2'b00;
  localparam logic [1:0] X_DEC = 2'b01;
  localparam logic [1:0] Y_INC = 2'b10;
  localparam logic [1:0] Y_DEC = 2'b11;

  logic       clk = 1'b0;
  logic       rst, start, empStck, moveReady;
  logic [7:0] locIn;
  logic       pop, moveValid, busy, finished, err;
  logic [1:0] moveDir;
  logic [7:0] moveLoc;
  logic [5:0] pathLen;

  logic [7:0] stk[$];
  logic [9:0] expQ[$];
  logic [9:0] expMove;
  int         nChecks = 0;
  int         nFails  = 0;
  int         popCnt  = 0;
  logic [1:0] snapDir;
  logic [7:0] snapLoc;
  int         snapPops;

  always #5 clk = ~clk;

  path_replayer #(.COORD_W(4), .LEN_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .emp_stck(empStck), .loc_in(locIn),
    .pop(pop), .move_valid(moveValid), .move_ready(moveReady), .move_dir(moveDir),
    .move_loc(moveLoc), .path_len(pathLen), .busy(busy), .finished(finished), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stack model: locOut valid the cycle after pop, empty flag follows the remaining depth.
  always @(posedge clk) begin
    if (pop) begin
      popCnt++;
      if (stk.size() > 0) locIn = stk.pop_front();
      empStck = (stk.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (!rst && moveValid && moveReady) begin
      if (expQ.size() == 0) chk("unexpected_move", 1, 0);
      else begin
        expMove = expQ.pop_front();
        chk("move_dir", moveDir, expMove[9:8]);
        chk("move_loc", moveLoc, expMove[7:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitEnd(input string tag);
    int n;
    n = 0;
    while (!(finished || err) && n < 400) begin
      tick();
      n++;
    end
    chk({tag, "_end_reached"}, finished || err, 1);
  endtask

  task automatic waitValid(input string tag);
    int n;
    n = 0;
    while (!moveValid && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_valid_reached"}, moveValid, 1);
  endtask

  task automatic checkIdleOutputs(input string tag);
    chk({tag, "_pop"}, pop, 0);
    chk({tag, "_move_valid"}, moveValid, 0);
    chk({tag, "_move_dir"}, moveDir, 0);
    chk({tag, "_move_loc"}, moveLoc, 0);
    chk({tag, "_path_len"}, pathLen, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_finished"}, finished, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic loadSquare();
    stk = '{8'h00, 8'h10, 8'h11, 8'h01};
    empStck = 1'b0;
    expQ.push_back({X_INC, 8'h10});
    expQ.push_back({Y_INC, 8'h11});
    expQ.push_back({X_DEC, 8'h01});
  endtask

  initial begin
    int row, col, x;
    rst = 1'b1; start = 1'b0; moveReady = 1'b0; empStck = 1'b1; locIn = '0;
    repeat (2) @(posedge clk);
    #1;
    checkIdleOutputs("in_reset");
    rst = 1'b0;
    tick();
    checkIdleOutputs("after_reset");

    // Empty stack: straight to DONE, no pop.
    popCnt = 0;
    pulseStart();
    chk("empty_finished", finished, 1);
    chk("empty_path_len", pathLen, 0);
    chk("empty_busy", busy, 0);
    tick();
    chk("empty_pops", popCnt, 0);

    // Square path with ready always high.
    popCnt = 0; moveReady = 1'b1;
    loadSquare();
    pulseStart();
    waitEnd("square");
    chk("square_finished", finished, 1);
    chk("square_path_len", pathLen, 3);
    chk("square_pops", popCnt, 4);
    chk("square_err", err, 0);

    // Backpressure in the first EMIT.
    popCnt = 0; moveReady = 1'b0;
    loadSquare();
    pulseStart();
    waitValid("bp");
    snapDir = moveDir; snapLoc = moveLoc; snapPops = popCnt;
    chk("bp_first_dir", moveDir, X_INC);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid_held", moveValid, 1);
      chk("bp_dir_stable", moveDir, snapDir);
      chk("bp_loc_stable", moveLoc, snapLoc);
      chk("bp_no_pop", popCnt, snapPops);
    end
    moveReady = 1'b1;
    waitEnd("bp");
    chk("bp_path_len", pathLen, 3);
    chk("bp_pops", popCnt, 4);

    // Two-cell jump (2,2)->(2,4) then (2,5).
    popCnt = 0;
    stk = '{8'h22, 8'h24, 8'h25};
    empStck = 1'b0;
`ifdef PATH_REPLAYER_CHECK_EN
    pulseStart();
    waitEnd("jump");
    chk("jump_err", err, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("jump_err_sticky", err, 1);
      chk("jump_no_valid", moveValid, 0);
    end
    chk("jump_pops", popCnt, 2);
    stk.delete();
    empStck = 1'b1;
    pulseStart();
    chk("jump_err_cleared", err, 0);
    chk("jump_restart_finished", finished, 1);
`else
    expQ.push_back({Y_INC, 8'h24});
    expQ.push_back({Y_INC, 8'h25});
    pulseStart();
    waitEnd("jump");
    chk("jump_err", err, 0);
    chk("jump_path_len", pathLen, 2);
    chk("jump_pops", popCnt, 3);
`endif

    // No wrap: (15,0)->(0,0).
    popCnt = 0;
    stk = '{8'hF0, 8'h00};
    empStck = 1'b0;
`ifdef PATH_REPLAYER_CHECK_EN
    pulseStart();
    waitEnd("wrap");
    chk("wrap_err", err, 1);
    chk("wrap_path_len", pathLen, 0);
`else
    expQ.push_back({X_DEC, 8'h00});
    pulseStart();
    waitEnd("wrap");
    chk("wrap_err", err, 0);
    chk("wrap_finished", finished, 1);
    chk("wrap_path_len", pathLen, 1);
`endif

    // Reset while a move is pending, then replay fresh data.
    moveReady = 1'b0;
    loadSquare();
    pulseStart();
    waitValid("rst_mid");
    rst = 1'b1;
    #1;
    checkIdleOutputs("rst_mid");
    expQ.delete();
    stk.delete();
    empStck = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    popCnt = 0; moveReady = 1'b1;
    stk = '{8'h33, 8'h32, 8'h42};
    empStck = 1'b0;
    expQ.push_back({Y_DEC, 8'h32});
    expQ.push_back({X_INC, 8'h42});
    pulseStart();
    chk("replay_len_start", pathLen, 0);
    waitEnd("replay");
    chk("replay_path_len", pathLen, 2);
    chk("replay_pops", popCnt, 3);

    // Snake of 65 moves: path_len saturates at 63.
    popCnt = 0;
    for (int i = 0; i < 66; i++) begin
      row = i / 16;
      col = i % 16;
      x = (row % 2 == 0) ? col : 15 - col;
      stk.push_back({4'(x), 4'(row)});
    end
    for (int i = 1; i < 66; i++) begin
      if (i % 16 == 0)            expQ.push_back({Y_INC, stk[i]});
      else if ((i / 16) % 2 == 0) expQ.push_back({X_INC, stk[i]});
      else                        expQ.push_back({X_DEC, stk[i]});
    end
    empStck = 1'b0;
    pulseStart();
    waitEnd("snake");
    chk("snake_path_len_sat", pathLen, 63);
    chk("snake_pops", popCnt, 66);

    chk("scoreboard_empty", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
